// File: rtl/regfile_dump_reader.sv
// Debug-side register file dumper: walks addresses 0..NUM_REGS-1, captures each
// word and streams it MSB-first as bytes over a valid/ready interface.
module regfile_dump_reader #(
  parameter int REGISTER_DEPTH  = 5,
  parameter int REGISTER_LENGTH = 32,
  parameter int NUM_REGS        = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [REGISTER_DEPTH-1:0]  rd_register_address,
  input  logic [REGISTER_LENGTH-1:0] rd_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int NBYTES = REGISTER_LENGTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0]             LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [REGISTER_DEPTH-1:0] LAST_ADDR = REGISTER_DEPTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_SEND, S_DONE} state_t;

  state_t                     r_state;
  logic [REGISTER_DEPTH-1:0]  r_addr;
  logic [REGISTER_LENGTH-1:0] r_shift;
  logic [CW-1:0]              r_cnt;
  logic                       r_valid;
  logic                       r_busy;
  logic                       r_done;
  logic                       w_accept;

  assign w_accept = r_valid && tx_ready;

  // ADDR is a full cycle of stable address so a one-cycle registered read
  // path still presents valid data by the time LOAD samples it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_ADDR;
          r_addr  <= '0;
          r_busy  <= 1'b1;
        end
        S_ADDR: r_state <= S_LOAD;
        S_LOAD: begin
          r_shift <= rd_data;
          r_cnt   <= '0;
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: if (w_accept) begin
          r_shift <= r_shift << 8;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_BYTE) begin
            r_valid <= 1'b0;
            if (r_addr == LAST_ADDR) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_register_address = r_addr;
  assign tx_data             = r_shift[REGISTER_LENGTH-1 -: 8];
  assign tx_valid            = r_valid;
  assign busy                = r_busy;
  assign done                = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: byte-queue model of the dump, per-cycle
// acceptance/stall checker, and directed scenarios with literal anchors.
module tb_regfile_dump_reader;
  localparam int DEP = 5, LEN = 32, NR = 32;

  logic clk = 1'b0;
  logic reset, start, tx_ready, tx_valid, busy, done;
  logic [DEP-1:0] addr;
  logic [LEN-1:0] rd_data, rd_q;
  logic [7:0]     tx_data;
  logic [LEN-1:0] regs [NR];
  logic           lat = 1'b0;

  int n_cmp = 0, n_bad = 0, n_done = 0, cyc = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];

  regfile_dump_reader #(.REGISTER_DEPTH(DEP), .REGISTER_LENGTH(LEN), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_register_address(addr),
    .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file: combinational or one-cycle registered read
  always @(posedge clk) rd_q <= regs[addr];
  assign rd_data = lat ? rd_q : regs[addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_dump();
    for (int r = 0; r < NR; r++)
      for (int b = LEN/8 - 1; b >= 0; b--)
        exp_q.push_back(regs[r][8*b +: 8]);
  endtask

  // Per-cycle checker: every accepted byte against the model, stall stability.
  logic       p_stall = 1'b0;
  logic [7:0] p_data;
  logic [DEP-1:0] p_addr;
  always @(negedge clk) begin
    if (reset) p_stall = 1'b0;
    else begin
      if (done) n_done++;
      if (p_stall) begin
        chk("stall valid held", 32'(tx_valid), 32'd1);
        chk("stall data held", 32'(tx_data), 32'(p_data));
        chk("stall addr held", 32'(addr), 32'(p_addr));
      end
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        if (exp_q.size() == 0) chk("unexpected byte", 32'(tx_data), 32'hFFFF_FFFF);
        else chk("byte stream", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      p_stall = tx_valid && !tx_ready;
      p_data  = tx_data;
      p_addr  = addr;
    end
  end

  task automatic pulse_start(output int s);
    start = 1'b1;
    @(negedge clk);
    s = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin at = cyc; break; end
    end
    if (at < 0) chk("done timeout", 32'd0, 32'd1);
  endtask

  task automatic check_word(input string nm, input int r, input logic [31:0] w);
    if (rx_q.size() >= 4*(r+1))
      chk(nm, {rx_q[4*r], rx_q[4*r+1], rx_q[4*r+2], rx_q[4*r+3]}, w);
    else chk({nm, " missing"}, 32'(rx_q.size()), 32'(4*(r+1)));
  endtask

  initial begin
    int s, d, nd0, idle, ndn;
    bit found;
    for (int i = 0; i < NR; i++) regs[i] = 32'hA0B0C000 + 32'(i);
    reset = 1'b1; start = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset addr", 32'(addr), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: ready tied high, timing of done
    push_dump(); rx_q.delete(); nd0 = n_done;
    pulse_start(s);
    chk("busy after start", 32'(busy), 32'd1);
    wait_done(400, d);
    chk("done latency", 32'(d - s), 32'd192);
    @(negedge clk);
    chk("busy falls", 32'(busy), 32'd0);
    chk("done one cycle", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    chk("t1 done count", 32'(n_done - nd0), 32'd1);
    chk("t1 byte count", 32'(rx_q.size()), 32'd128);
    check_word("t1 reg0", 0, 32'hA0B0C000);
    check_word("t1 reg1", 1, 32'hA0B0C001);
    check_word("t1 reg31", 31, 32'hA0B0C01F);

    // 2: random ready, spurious start pulses while busy
    push_dump(); rx_q.delete(); nd0 = n_done;
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      tx_ready = ($urandom_range(0, 9) < 3);
      start = !found && (rx_q.size() < 100) && ($urandom_range(0, 7) == 0);
    end
    if (!found) chk("t2 done timeout", 32'd0, 32'd1);
    start = 1'b0; tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("t2 byte count", 32'(rx_q.size()), 32'd128);
    chk("t2 queue drained", 32'(exp_q.size()), 32'd0);
    chk("t2 idle after", 32'(busy), 32'd0);
    chk("t2 done count", 32'(n_done - nd0), 32'd1);
    check_word("t2 reg31", 31, 32'hA0B0C01F);

    // 3: asynchronous reset mid register 5
    regs[5] = 32'h12345678;
    push_dump(); rx_q.delete();
    pulse_start(s);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (tx_valid && addr == 5'd5 && tx_data == 8'h56) found = 1'b1;
      else @(negedge clk);
    end
    chk("t3 reached reg5 byte2", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async tx_valid", 32'(tx_valid), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async addr", 32'(addr), 32'd0);
    chk("async tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); rx_q.delete();
    @(negedge clk);
    push_dump();
    pulse_start(s);
    wait_done(400, d);
    repeat (3) @(negedge clk);
    chk("t3 byte count", 32'(rx_q.size()), 32'd128);
    check_word("t3 reg0 restart", 0, 32'hA0B0C000);
    check_word("t3 reg5", 5, 32'h12345678);

    // 4: start held high, back-to-back dumps
    push_dump(); push_dump(); push_dump(); rx_q.delete();
    nd0 = n_done; idle = 0; ndn = 0;
    start = 1'b1;
    for (int i = 0; i < 2000 && ndn < 3; i++) begin
      @(negedge clk);
      if (done) begin ndn++; if (ndn == 3) start = 1'b0; end
      if (!busy) idle++;
      else if (idle > 0) begin chk("idle gap", 32'(idle), 32'd1); idle = 0; end
    end
    repeat (10) @(negedge clk);
    chk("t4 done count", 32'(n_done - nd0), 32'd3);
    chk("t4 byte count", 32'(rx_q.size()), 32'd384);
    chk("t4 queue drained", 32'(exp_q.size()), 32'd0);
    chk("t4 idle after", 32'(busy), 32'd0);

    // 5: registered read latency
    lat = 1'b1;
    push_dump(); rx_q.delete();
    pulse_start(s);
    wait_done(400, d);
    repeat (3) @(negedge clk);
    chk("t5 byte count", 32'(rx_q.size()), 32'd128);
    check_word("t5 reg0", 0, 32'hA0B0C000);
    check_word("t5 reg5", 5, 32'h12345678);
    check_word("t5 reg31", 31, 32'hA0B0C01F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
